// File: rtl/chan_op_pipe_pkg.sv
// Shared definitions for the channel operator pipeline: operator encodings
// selected by the runtime mode input.
package chan_op_pipe_pkg;

  typedef enum logic [1:0] {
    OP_AND  = 2'b00,
    OP_OR   = 2'b01,
    OP_PREV = 2'b10,
    OP_CUR  = 2'b11
  } op_e;

endpackage

// File: rtl/chan_op_pipe_skid_buf.sv
// Two-entry skid buffer (main + skid). in_ready depends only on registered
// state, so there is no combinational path from out_ready to in_ready.
module skid_buf
  import chan_op_pipe_pkg::*;
#(
  parameter int DW = 12
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_data
);

  logic          r_main_v;
  logic          r_skid_v;
  logic [DW-1:0] r_main_d;
  logic [DW-1:0] r_skid_d;
  logic          w_in_xfer;
  logic          w_out_xfer;

  assign in_ready   = ~r_skid_v;
  assign out_valid  = r_main_v;
  assign out_data   = r_main_d;
  assign w_in_xfer  = in_valid & ~r_skid_v;
  assign w_out_xfer = r_main_v & out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_main_v <= 1'b0;
      r_skid_v <= 1'b0;
      r_main_d <= '0;
      r_skid_d <= '0;
    end else if (w_out_xfer) begin
      // skid full implies in_ready=0, so no new beat competes with the move
      if (r_skid_v) begin
        r_main_d <= r_skid_d;
        r_skid_v <= 1'b0;
      end else if (w_in_xfer) begin
        r_main_d <= in_data;
      end else begin
        r_main_v <= 1'b0;
      end
    end else if (w_in_xfer) begin
      if (!r_main_v) begin
        r_main_d <= in_data;
        r_main_v <= 1'b1;
      end else begin
        r_skid_d <= in_data;
        r_skid_v <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/chan_op_pipe.sv
// Multi-channel operator stage: combines each channel with its previous
// accepted input, optionally holds the last checked result, then skid-buffers.
module chan_op_pipe
  import chan_op_pipe_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int NCH   = 3,
  parameter int CNT_W = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [NCH*WIDTH-1:0] in_data,
  input  logic [1:0]           mode,
  input  logic                 check,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [NCH*WIDTH-1:0] out_data,
  output logic [CNT_W-1:0]     out_count
);

  localparam int DW = NCH * WIDTH;

  logic [DW-1:0]    r_prev;
  logic [DW-1:0]    r_last;
  logic [CNT_W-1:0] r_count;
  logic [DW-1:0]    w_op;
  logic [DW-1:0]    w_result;
  logic             w_in_xfer;
  logic             w_out_xfer;

  for (genvar c = 0; c < NCH; c++) begin : g_ch
    logic [WIDTH-1:0] w_cur;
    logic [WIDTH-1:0] w_prv;
    logic [WIDTH-1:0] w_res;

    assign w_cur = in_data[c*WIDTH +: WIDTH];
    assign w_prv = r_prev[c*WIDTH +: WIDTH];

    always_comb begin
      w_res = w_cur;
      case (op_e'(mode))
        OP_AND:  w_res = w_cur & w_prv;
        OP_OR:   w_res = w_cur | w_prv;
        OP_PREV: w_res = w_prv;
        OP_CUR:  w_res = w_cur;
        default: w_res = w_cur;
      endcase
    end

    assign w_op[c*WIDTH +: WIDTH] = w_res;
  end

  assign w_result   = check ? w_op : r_last;
  assign w_in_xfer  = in_valid & in_ready;
  assign w_out_xfer = out_valid & out_ready;
  assign out_count  = r_count;

  // prev tracks every accepted beat; last only tracks checked results
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_prev  <= '0;
      r_last  <= '0;
      r_count <= '0;
    end else begin
      if (w_in_xfer) begin
        r_prev <= in_data;
        if (check) r_last <= w_op;
      end
      if (w_out_xfer) r_count <= r_count + 1'b1;
    end
  end

  skid_buf #(.DW(DW)) u_skid (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (w_result),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data)
  );

endmodule

// File: tb/tb_chan_op_pipe.sv
// Scoreboard bench for chan_op_pipe: a word-level reference model feeds an
// expected-result queue that an independent monitor drains.
module tb_chan_op_pipe;

  localparam int WIDTH = 4;
  localparam int NCH   = 3;
  localparam int CNT_W = 4;
  localparam int DW    = NCH * WIDTH;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [DW-1:0]    in_data = '0;
  logic [1:0]       mode = 2'b00;
  logic             check = 1'b0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [DW-1:0]    out_data;
  logic [CNT_W-1:0] out_count;

  chan_op_pipe #(.WIDTH(WIDTH), .NCH(NCH), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .mode      (mode),
    .check     (check),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_count (out_count)
  );

  always #5 clk = ~clk;

  logic [DW-1:0]    exp_q[$];
  logic [DW-1:0]    m_prev = '0;
  logic [DW-1:0]    m_last = '0;
  logic [CNT_W-1:0] exp_count = '0;
  logic             pend = 1'b0;
  logic [DW-1:0]    pend_val = '0;
  int               n_vec = 0;
  int               n_cmp = 0;
  int               n_err = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Operators are bitwise, so applying them to the packed word covers every channel.
  function automatic logic [DW-1:0] model_op(input logic [DW-1:0] cur, input logic [DW-1:0] prv,
                                             input logic [1:0] m);
    case (m)
      2'd0:    return cur & prv;
      2'd1:    return cur | prv;
      2'd2:    return prv;
      default: return cur;
    endcase
  endfunction

  // One clock: commit the previous acceptance, drive new inputs, note acceptance.
  task automatic cycle(input logic v, input logic [DW-1:0] d, input logic [1:0] m,
                       input logic c, input logic ordy, output logic acc);
    logic [DW-1:0] r;
    @(posedge clk);
    if (pend) exp_q.push_back(pend_val);
    pend = 1'b0;
    #1;
    in_valid = v; in_data = d; mode = m; check = c; out_ready = ordy;
    @(negedge clk);
    acc = rst_n && in_valid && in_ready;
    if (acc) begin
      r = c ? model_op(d, m_prev, m) : m_last;
      if (c) m_last = r;
      m_prev   = d;
      pend     = 1'b1;
      pend_val = r;
      n_vec++;
    end
  endtask

  task automatic send(input logic [DW-1:0] d, input logic [1:0] m, input logic c, input logic ordy);
    logic acc;
    for (int i = 0; i < 50; i++) begin
      cycle(1'b1, d, m, c, ordy, acc);
      if (acc) return;
    end
    chk("send_timeout", 32'd0, 32'd1);
  endtask

  task automatic idle(input int n, input logic ordy);
    logic acc;
    for (int i = 0; i < n; i++) cycle(1'b0, '0, 2'b00, 1'b0, ordy, acc);
  endtask

  always @(negedge clk) begin
    chk("out_valid", 32'(out_valid), 32'(exp_q.size() > 0));
    chk("in_ready", 32'(in_ready), 32'(exp_q.size() < 2));
    if (out_valid && exp_q.size() > 0) begin
      chk("out_data", 32'(out_data), 32'(exp_q[0]));
      if (out_ready && rst_n) begin
        chk("out_count", 32'(out_count), 32'(exp_count));
        exp_count = exp_count + 1'b1;
        void'(exp_q.pop_front());
      end
    end
  end

  initial begin
    logic acc;
    repeat (3) @(negedge clk);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data", 32'(out_data), 32'd0);
    chk("rst_out_count", 32'(out_count), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk); #1 rst_n = 1'b1;

    send(12'hABC, 2'b00, 1'b1, 1'b1);
    send(12'h5A3, 2'b01, 1'b1, 1'b1);
    send(12'h111, 2'b10, 1'b1, 1'b1);
    send(12'h777, 2'b00, 1'b0, 1'b1);
    send(12'h222, 2'b10, 1'b1, 1'b1);
    idle(3, 1'b1);

    send(12'h001, 2'b11, 1'b1, 1'b0);
    send(12'h002, 2'b11, 1'b1, 1'b0);
    cycle(1'b1, 12'h003, 2'b11, 1'b1, 1'b0, acc);
    chk("bp_in_ready_low", 32'(in_ready), 32'd0);
    chk("bp_third_held", 32'(acc), 32'd0);
    idle(3, 1'b0);
    send(12'h003, 2'b11, 1'b1, 1'b1);
    idle(4, 1'b1);
    chk("bp_in_ready_back", 32'(in_ready), 32'd1);

    send(12'hF00, 2'b11, 1'b1, 1'b0);
    send(12'hF00, 2'b11, 1'b1, 1'b0);
    @(posedge clk);
    if (pend) exp_q.push_back(pend_val);
    #1 rst_n = 1'b0;
    in_valid = 1'b0;
    exp_q.delete();
    pend = 1'b0; m_prev = '0; m_last = '0; exp_count = '0;
    #1;
    chk("async_rst_out_valid", 32'(out_valid), 32'd0);
    chk("async_rst_out_data", 32'(out_data), 32'd0);
    chk("async_rst_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk); #1 rst_n = 1'b1;

    send(12'h0F0, 2'b01, 1'b1, 1'b1);
    for (int i = 0; i < 16; i++) send(12'($urandom), 2'($urandom), 1'($urandom), 1'b1);
    idle(4, 1'b1);
    chk("count_wrap", 32'(out_count), 32'd1);

    for (int i = 0; i < 400; i++)
      cycle(($urandom % 10) < 7, 12'($urandom), 2'($urandom), ($urandom % 4) != 0,
            ($urandom % 10) < 6, acc);
    idle(8, 1'b1);
    chk("drained", 32'(exp_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
